scan_shift_ctrl: RTL

//  Scan-test sequencer driving the se/si/so pins of a scan-inserted block (e.g. the 4-bit

---
 rtl/scan_shift_ctrl_pkg.sv | 24 ++
 rtl/scan_shift_ctrl_bit_counter.sv | 29 ++
 rtl/scan_shift_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/scan_shift_ctrl_pkg.sv
// Shared definitions for scan controllers: state encoding and default chain length.
package scan_shift_ctrl_pkg;

   localparam int DEF_CHAIN_LEN = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SHIFT_IN  = 3'd1,
      ST_CAPTURE   = 3'd2,
      ST_SHIFT_OUT = 3'd3,
      ST_DONE      = 3'd4
   } scan_state_t;

   // A state drives se high only while the chain is being shifted.
   function automatic logic is_shift_state(input scan_state_t st);
      return (st == ST_SHIFT_IN) || (st == ST_SHIFT_OUT);
   endfunction

   // busy covers the whole chain-touching window: both shifts and the capture cycle.
   function automatic logic is_busy_state(input scan_state_t st);
      return (st == ST_SHIFT_IN) || (st == ST_CAPTURE) || (st == ST_SHIFT_OUT);
   endfunction

endpackage

// File: rtl/scan_shift_ctrl_bit_counter.sv
// Bit counter for scan shifting: sync clear, enable, terminal flag on the last bit.
module scan_bit_counter #(
   parameter int CHAIN_LEN = 4,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             term
);

   // Counts shifted bits; clear has priority so every state change restarts at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CNT_W'(1);
   end

   // Terminal flag marks the last bit of a shift phase.
   always_comb begin
      term = (cnt == CNT_W'(CHAIN_LEN - 1));
   end

endmodule

// File: rtl/scan_shift_ctrl.sv
// Scan-test sequencer: load pattern, one capture cycle, unload and compare.
module scan_shift_ctrl
   import scan_shift_ctrl_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern_in,
   input  logic [CHAIN_LEN-1:0] expect_in,
   output logic                 se,
   output logic                 si,
   input  logic                 so,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CHAIN_LEN-1:0] captured
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);

   scan_state_t          state, state_nxt;
   logic                 cnt_clr, cnt_en, term;
   logic [CNT_W-1:0]     cnt;
   logic [CHAIN_LEN-1:0] pat_q, exp_q;
   logic                 accept;

   scan_bit_counter #(
      .CHAIN_LEN (CHAIN_LEN),
      .CNT_W     (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .cnt     (cnt),
      .term    (term)
   );

   assign accept = (state == ST_IDLE) && start;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state and counter control; counter clears on every state change.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_SHIFT_IN;
               cnt_clr   = 1'b1;
            end
         end
         ST_SHIFT_IN: begin
            if (term) begin
               state_nxt = ST_CAPTURE;
               cnt_clr   = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_CAPTURE: begin
            state_nxt = ST_SHIFT_OUT;
            cnt_clr   = 1'b1;
         end
         ST_SHIFT_OUT: begin
            if (term) begin
               state_nxt = ST_DONE;
               cnt_clr   = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
         end
      endcase
   end

   // Control outputs registered from the next state so they switch cleanly at the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         se   <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         se   <= is_shift_state(state_nxt);
         busy <= is_busy_state(state_nxt);
         done <= (state_nxt == ST_DONE);
      end
   end

   // Pattern serializer, capture deserializer and result compare.
   // si is registered one bit ahead: the accept edge presents the MSB, and each
   // non-final shift edge presents the bit selected by the current count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pat_q    <= '0;
         exp_q    <= '0;
         si       <= 1'b0;
         pass     <= 1'b0;
         captured <= '0;
      end else if (accept) begin
         pat_q <= pattern_in;
         exp_q <= expect_in;
         si    <= pattern_in[CHAIN_LEN-1];
         pass  <= 1'b0;
      end else begin
         case (state)
            ST_SHIFT_IN: begin
               if (term)
                  si <= 1'b0;
               else
                  si <= pat_q[CHAIN_LEN - 2 - int'(cnt)];
            end
            ST_SHIFT_OUT: begin
               // so still shows the pre-shift last flop at this edge.
               captured <= {captured[CHAIN_LEN-2:0], so};
               if (term)
                  pass <= ({captured[CHAIN_LEN-2:0], so} == exp_q);
            end
            default: si <= 1'b0;
         endcase
      end
   end

endmodule
